tnn_vote_accumulator: RTL and testbench

- Downstream stage of the 3-bit TNN comparator neurons (a+b vs threshold c, 1-bit decision).
- Consumes a serial stream of neuron decisions, each tagged with the class it votes for.
- Keeps a vote counter per class; at end of sample scans the counters sequentially for the argmax.
- Presents the winning class on a valid/ready output port; feeds the classification result/accuracy logic.

---
 rtl/tnn_vote_accumulator_if.sv | 26 ++
 rtl/tnn_vote_accumulator.sv | 109 ++++++++++
 tb/tb_tnn_vote_accumulator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tnn_vote_accumulator_if.sv
// Decision-beat input stream and classification result port of the TNN vote accumulator.
interface tnn_vote_accumulator_if #(
  parameter int unsigned CLS_W = 3,
  parameter int unsigned CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [CLS_W-1:0] in_class;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CLS_W-1:0] out_class;
  logic [CNT_W-1:0] out_votes;
  logic             err_class;

  modport master (
    output in_valid, in_bit, in_class, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_votes, err_class
  );

  modport slave (
    input  in_valid, in_bit, in_class, in_last, out_ready,
    output in_ready, out_valid, out_class, out_votes, err_class
  );
endinterface

// File: rtl/tnn_vote_accumulator.sv
// Per-class vote counters fed by a serial stream of neuron decisions; a sequential
// argmax scan at end of sample produces the winning class on a valid/ready port.
module tnn_vote_accumulator #(
  parameter int unsigned N_CLASSES = 7,
  parameter int unsigned CLS_W     = 3,
  parameter int unsigned CNT_W     = 6
) (
  input logic             clk,
  input logic             rst,
  tnn_vote_accumulator_if.slave bus
);
  // One spare bit lets the scan index reach N_CLASSES as its terminal step.
  localparam int unsigned IDX_W = CLS_W + 1;

  typedef enum logic [1:0] {StAccum, StScan, StOut} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_CLASSES];
  logic [CNT_W-1:0] cnt_d [N_CLASSES];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] best_class_q, best_class_d;
  logic [CNT_W-1:0] best_votes_q, best_votes_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scan_votes;
  logic             class_ok;
  logic             beat;

  assign class_ok = (32'(bus.in_class) < N_CLASSES);
  assign beat     = bus.in_valid && bus.in_ready;

  always_comb begin
    scan_votes = '0;
    for (int unsigned i = 0; i < N_CLASSES; i++) begin
      if (idx_q == IDX_W'(i)) scan_votes = cnt_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    best_class_d = best_class_q;
    best_votes_d = best_votes_q;
    err_d        = err_q;
    unique case (state_q)
      StAccum: begin
        if (beat) begin
          if (!class_ok) begin
            err_d = 1'b1;
          end else if (bus.in_bit) begin
            for (int unsigned i = 0; i < N_CLASSES; i++) begin
              if (bus.in_class == CLS_W'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          if (bus.in_last) begin
            state_d = StScan;
            idx_d   = '0;
          end
        end
      end
      StScan: begin
        if (idx_q == IDX_W'(N_CLASSES)) begin
          state_d = StOut;
        end else begin
          // Strict compare keeps the lowest index on ties.
          if (idx_q == '0 || scan_votes > best_votes_q) begin
            best_class_d = idx_q[CLS_W-1:0];
            best_votes_d = scan_votes;
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StAccum;
          for (int unsigned i = 0; i < N_CLASSES; i++) cnt_d[i] = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StAccum;
      cnt_q        <= '{default: '0};
      idx_q        <= '0;
      best_class_q <= '0;
      best_votes_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      best_class_q <= best_class_d;
      best_votes_q <= best_votes_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StAccum) && !rst;
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_class = best_class_q;
  assign bus.out_votes = best_votes_q;
  assign bus.err_class = err_q;

endmodule

// File: tb/tb_tnn_vote_accumulator.sv
// Directed bench for tnn_vote_accumulator with a per-cycle behavioural model of votes,
// latency and handshakes, plus literal expectations for each sample's result.
module tb_tnn_vote_accumulator;
  localparam int NC = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tnn_vote_accumulator_if #(.CLS_W(3), .CNT_W(6)) bus ();

  tnn_vote_accumulator #(.N_CLASSES(NC), .CLS_W(3), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 = collecting votes, 1 = result pending, 2 = result offered.
  int m_cnt [NC];
  int m_phase = 0;
  int m_wait  = 0;
  int m_c     = 0;
  int m_v     = 0;
  int m_err   = 0;
  int res_c [$];
  int res_v [$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_phase = 0;
        m_err   = 0;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_err_class", int'(bus.err_class), 0);
      end else begin
        chk("in_ready", int'(bus.in_ready), int'(m_phase == 0));
        chk("out_valid", int'(bus.out_valid), int'(m_phase == 2));
        chk("err_class", int'(bus.err_class), m_err);
        if (m_phase == 2) begin
          chk("out_class", int'(bus.out_class), m_c);
          chk("out_votes", int'(bus.out_votes), m_v);
        end
        case (m_phase)
          0: if (bus.in_valid) begin
            if (int'(bus.in_class) >= NC) m_err = 1;
            else if (bus.in_bit && m_cnt[bus.in_class] < 63) m_cnt[bus.in_class]++;
            if (bus.in_last) begin
              m_c = 0;
              m_v = m_cnt[0];
              for (int i = 1; i < NC; i++) begin
                if (m_cnt[i] > m_v) begin
                  m_c = i;
                  m_v = m_cnt[i];
                end
              end
              m_phase = 1;
              m_wait  = NC + 1;
            end
          end
          1: begin
            m_wait--;
            if (m_wait == 0) m_phase = 2;
          end
          default: if (bus.out_ready) begin
            res_c.push_back(int'(bus.out_class));
            res_v.push_back(int'(bus.out_votes));
            for (int i = 0; i < NC; i++) m_cnt[i] = 0;
            m_phase = 0;
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input int c, input logic l);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_class = 3'(c);
    bus.in_last  = l;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat class %0d not accepted, in_ready=%0d", c, bus.in_ready);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_out(input string name, input int c, input int v);
    bit found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      found = bus.out_valid;
    end
    chk({name, "_seen"}, int'(found), 1);
    chk({name, "_class"}, int'(bus.out_class), c);
    chk({name, "_votes"}, int'(bus.out_votes), v);
    step();
  endtask

  int exp_c [8] = '{1, 5, 4, 3, 6, 0, 0, 2};
  int exp_v [8] = '{4, 3, 63, 2, 1, 2, 0, 2};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_class  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_class", int'(bus.out_class), 0);
    chk("reset_out_votes", int'(bus.out_votes), 0);
    chk("reset_err_class", int'(bus.err_class), 0);
    step();

    // Classes 1 and 2 both reach 4 votes; tie goes to class 1.
    for (int i = 1; i <= 12; i++) send(logic'((i % 3) != 0), i % 3, logic'(i == 12));
    idle(0);
    wait_out("tie", 1, 4);
    idle(2);

    // Result held under back-pressure.
    bus.out_ready = 1'b0;
    send(1, 5, 0); send(1, 2, 0); send(0, 3, 0); send(1, 5, 0);
    send(1, 0, 0); send(1, 2, 0); send(1, 5, 1);
    idle(0);
    wait_out("hold", 5, 3);
    idle(10);
    @(negedge clk);
    chk("hold_class_late", int'(bus.out_class), 5);
    chk("hold_in_ready", int'(bus.in_ready), 0);
    step();
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("release_in_ready", int'(bus.in_ready), 1);
    step();

    // Saturation.
    for (int i = 1; i <= 70; i++) send(1, 4, logic'(i == 70));
    idle(0);
    wait_out("sat", 4, 63);
    idle(2);

    // Out-of-range class sets the sticky error and adds nothing.
    send(1, 7, 0); send(1, 3, 0); send(1, 1, 0); send(1, 3, 1);
    idle(0);
    wait_out("err", 3, 2);
    idle(3);
    @(negedge clk);
    chk("err_sticky", int'(bus.err_class), 1);
    step();

    // Reset during the scan discards the sample.
    send(1, 2, 0); send(1, 2, 1);
    idle(0);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_err", int'(bus.err_class), 0);
    step();
    idle(20);
    send(1, 6, 1);
    idle(0);
    wait_out("after_rst", 6, 1);
    idle(2);

    // Back-to-back samples with in_valid held high across scans.
    send(1, 0, 0); send(1, 0, 0); send(1, 3, 1);
    send(0, 1, 1);
    send(1, 2, 0); send(1, 2, 1);
    idle(20);

    chk("n_results", res_c.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < res_c.size()) begin
        chk($sformatf("res%0d_class", i), res_c[i], exp_c[i]);
        chk($sformatf("res%0d_votes", i), res_v[i], exp_v[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
